// File: rtl/l2_cache_dir_pkg.sv
// Shared L2 pipeline definitions: address field widths, request opcodes,
// requesting unit IDs, the request packet, and a way-tag extraction helper.
package l2_cache_dir_pkg;

  localparam int unsigned L2_NUM_CORES       = 4;
  localparam int unsigned CORE_INDEX_WIDTH   = 2;
  localparam int unsigned CACHE_LINE_BITS    = 512;
  localparam int unsigned L2_ADDR_WIDTH      = 26;  // cache-line address
  localparam int unsigned L2_SET_INDEX_WIDTH = 8;
  localparam int unsigned L2_TAG_WIDTH       = L2_ADDR_WIDTH - L2_SET_INDEX_WIDTH;
  localparam int unsigned L1_SET_INDEX_WIDTH = 6;
  localparam int unsigned L1_TAG_WIDTH       = L2_ADDR_WIDTH - L1_SET_INDEX_WIDTH;
  localparam int unsigned L2_WAYS            = 4;

  typedef enum logic [2:0] {
    L2REQ_LOAD        = 3'd0,
    L2REQ_STORE       = 3'd1,
    L2REQ_FLUSH       = 3'd2,
    L2REQ_DINVALIDATE = 3'd3,
    L2REQ_IINVALIDATE = 3'd4,
    L2REQ_STORE_SYNC  = 3'd5,
    L2REQ_LOAD_SYNC   = 3'd6
  } l2req_op_t;

  typedef enum logic [1:0] {
    L2REQ_UNIT_ICACHE = 2'd0,
    L2REQ_UNIT_DCACHE = 2'd1,
    L2REQ_UNIT_STBUF  = 2'd2
  } l2req_unit_t;

  typedef struct packed {
    logic                        valid;
    logic [CORE_INDEX_WIDTH-1:0] core;
    l2req_unit_t                 unit;
    l2req_op_t                   op;
    logic [1:0]                  way;      // L1 way for directory updates
    logic [L2_ADDR_WIDTH-1:0]    address;
  } l2req_packet_t;

  function automatic logic [L2_TAG_WIDTH-1:0] get_way_tag(
    input logic [L2_TAG_WIDTH*L2_WAYS-1:0] tags,
    input logic [1:0]                      way
  );
    return tags[way*L2_TAG_WIDTH +: L2_TAG_WIDTH];
  endfunction

endpackage

// File: rtl/l2_cache_dir_if.sv
// Directory writeback bus from the L2 dir stage back to the tag stage:
// L2 tag/valid write, dirty-bit write, L1 directory write and LRU hit way.
// master: dir stage (drives), slave: tag stage (consumes).
interface l2_cache_dir_if;
  import l2_cache_dir_pkg::*;

  logic                          dir_update_tag_enable;
  logic                          dir_update_tag_valid;
  logic [L2_TAG_WIDTH-1:0]       dir_update_tag_tag;
  logic [L2_SET_INDEX_WIDTH-1:0] dir_update_tag_set;
  logic [1:0]                    dir_update_tag_way;
  logic [L2_SET_INDEX_WIDTH-1:0] dir_update_dirty_set;
  logic                          dir_new_dirty;
  logic [L2_WAYS-1:0]            dir_update_dirty;
  logic                          dir_update_directory;
  logic                          dir_update_dir_valid;
  logic [CORE_INDEX_WIDTH-1:0]   dir_update_dir_core;
  logic [1:0]                    dir_update_dir_way;
  logic [L1_TAG_WIDTH-1:0]       dir_update_dir_tag;
  logic [L1_SET_INDEX_WIDTH-1:0] dir_update_dir_set;
  logic [1:0]                    dir_hit_l2_way;

  modport master (
    output dir_update_tag_enable, dir_update_tag_valid, dir_update_tag_tag,
           dir_update_tag_set, dir_update_tag_way, dir_update_dirty_set,
           dir_new_dirty, dir_update_dirty, dir_update_directory,
           dir_update_dir_valid, dir_update_dir_core, dir_update_dir_way,
           dir_update_dir_tag, dir_update_dir_set, dir_hit_l2_way
  );

  modport slave (
    input dir_update_tag_enable, dir_update_tag_valid, dir_update_tag_tag,
          dir_update_tag_set, dir_update_tag_way, dir_update_dirty_set,
          dir_new_dirty, dir_update_dirty, dir_update_directory,
          dir_update_dir_valid, dir_update_dir_core, dir_update_dir_way,
          dir_update_dir_tag, dir_update_dir_set, dir_hit_l2_way
  );
endinterface

// File: rtl/l2_way_hit_encoder.sv
// Per-way tag compare and hit encoding.
// Ports: way_tags (way0 at LSBs), way_valid, req_tag in;
//        hit_oh (one-hot hit per way), hit_way (encoded, 0 on no hit) out.
module l2_way_hit_encoder
  import l2_cache_dir_pkg::*;
#(
  parameter int unsigned NUM_WAYS = 4
) (
  input  logic [L2_TAG_WIDTH*NUM_WAYS-1:0] way_tags,
  input  logic [NUM_WAYS-1:0]              way_valid,
  input  logic [L2_TAG_WIDTH-1:0]          req_tag,
  output logic [NUM_WAYS-1:0]              hit_oh,
  output logic [1:0]                       hit_way
);

  always_comb begin
    hit_oh  = '0;
    hit_way = '0;
    for (int unsigned w = 0; w < NUM_WAYS; w++) begin
      hit_oh[w] = way_valid[w] && (way_tags[w*L2_TAG_WIDTH +: L2_TAG_WIDTH] == req_tag);
      if (hit_oh[w]) hit_way = w[1:0];
    end
  end

endmodule

// File: rtl/l2_cache_dir.sv
// L2 directory stage: resolves hit/miss against the 4 way tags, drives the
// same-cycle directory writeback bus to the tag stage, and registers the
// request plus hit/writeback status for the read/writeback stage.
// Ports: clk, reset (async, active-high); tag_* inputs from the tag stage;
//        dir_if (master) combinational updates; dir_* registered outputs;
//        pc_event_hit/miss combinational event pulses.
module l2_cache_dir
  import l2_cache_dir_pkg::*;
#(
  parameter int unsigned NUM_WAYS  = 4,   // fixed: way indices are 2 bits
  parameter int unsigned NUM_CORES = L2_NUM_CORES
) (
  input  logic                          clk,
  input  logic                          reset,
  input  l2req_packet_t                 tag_l2req_packet,
  input  logic                          tag_is_l2_fill,
  input  logic [CACHE_LINE_BITS-1:0]    tag_data_from_memory,
  input  logic [1:0]                    tag_miss_fill_l2_way,
  input  logic [L2_TAG_WIDTH*NUM_WAYS-1:0] tag_l2_tag,
  input  logic [NUM_WAYS-1:0]           tag_l2_valid,
  input  logic [NUM_WAYS-1:0]           tag_l2_dirty,
  input  logic [NUM_CORES-1:0]          tag_l1_has_line,
  input  logic [NUM_CORES*2-1:0]        tag_l1_way,
  l2_cache_dir_if.master                dir_if,
  output l2req_packet_t                 dir_l2req_packet,
  output logic                          dir_is_l2_fill,
  output logic                          dir_cache_hit,
  output logic                          dir_needs_writeback,
  output logic [1:0]                    dir_hit_l2_way_q,
  output logic [L2_TAG_WIDTH-1:0]       dir_old_l2_tag,
  output logic [CACHE_LINE_BITS-1:0]    dir_data_from_memory,
  output logic [NUM_CORES-1:0]          dir_l1_has_line,
  output logic [NUM_CORES*2-1:0]        dir_l1_way,
  output logic                          pc_event_hit,
  output logic                          pc_event_miss
);

  logic [L2_SET_INDEX_WIDTH-1:0] req_set;
  logic [L2_TAG_WIDTH-1:0]       req_tag;
  logic [L1_SET_INDEX_WIDTH-1:0] l1_set;
  logic [L1_TAG_WIDTH-1:0]       l1_tag;
  logic [NUM_WAYS-1:0]           hit_oh;
  logic [1:0]                    hit_way_enc;
  logic                          any_hit;
  logic                          fill;
  logic                          cache_hit;
  logic [1:0]                    way_in_use;
  logic                          needs_wb_d;

  l2req_packet_t                 pkt_q;
  logic                          fill_q, hit_q, needs_wb_q;
  logic [1:0]                    way_q;
  logic [L2_TAG_WIDTH-1:0]       old_tag_q;
  logic [CACHE_LINE_BITS-1:0]    data_q;
  logic [NUM_CORES-1:0]          l1_has_line_q;
  logic [NUM_CORES*2-1:0]        l1_way_q;

  assign req_set = tag_l2req_packet.address[L2_SET_INDEX_WIDTH-1:0];
  assign req_tag = tag_l2req_packet.address[L2_SET_INDEX_WIDTH +: L2_TAG_WIDTH];
  assign l1_set  = tag_l2req_packet.address[L1_SET_INDEX_WIDTH-1:0];
  assign l1_tag  = tag_l2req_packet.address[L1_SET_INDEX_WIDTH +: L1_TAG_WIDTH];

  l2_way_hit_encoder #(.NUM_WAYS(NUM_WAYS)) u_hit_enc (
    .way_tags  (tag_l2_tag),
    .way_valid (tag_l2_valid),
    .req_tag   (req_tag),
    .hit_oh    (hit_oh),
    .hit_way   (hit_way_enc)
  );

  assign any_hit    = |hit_oh;
  assign fill       = tag_l2req_packet.valid && tag_is_l2_fill;
  assign cache_hit  = tag_l2req_packet.valid && any_hit && !tag_is_l2_fill;
  // A fill always lands in the LRU victim; otherwise the hit way is in use.
  assign way_in_use = tag_is_l2_fill ? tag_miss_fill_l2_way : hit_way_enc;

  assign pc_event_hit  = cache_hit;
  assign pc_event_miss = tag_l2req_packet.valid && !any_hit && !tag_is_l2_fill;

  always_comb begin
    dir_if.dir_update_tag_enable = 1'b0;
    dir_if.dir_update_tag_valid  = 1'b0;
    dir_if.dir_update_tag_tag    = '0;
    dir_if.dir_update_tag_set    = '0;
    dir_if.dir_update_tag_way    = '0;
    dir_if.dir_update_dirty_set  = '0;
    dir_if.dir_new_dirty         = 1'b0;
    dir_if.dir_update_dirty      = '0;
    dir_if.dir_update_directory  = 1'b0;
    dir_if.dir_update_dir_valid  = 1'b0;
    dir_if.dir_update_dir_core   = '0;
    dir_if.dir_update_dir_way    = '0;
    dir_if.dir_update_dir_tag    = '0;
    dir_if.dir_update_dir_set    = '0;
    dir_if.dir_hit_l2_way        = '0;
    needs_wb_d                   = 1'b0;

    if (tag_l2req_packet.valid) begin
      dir_if.dir_update_tag_tag   = req_tag;
      dir_if.dir_update_tag_set   = req_set;
      dir_if.dir_update_tag_way   = way_in_use;
      dir_if.dir_update_dirty_set = req_set;
      dir_if.dir_update_dir_core  = tag_l2req_packet.core;
      dir_if.dir_update_dir_way   = tag_l2req_packet.way;
      dir_if.dir_update_dir_tag   = l1_tag;
      dir_if.dir_update_dir_set   = l1_set;
      if (cache_hit) dir_if.dir_hit_l2_way = hit_way_enc;

      if (fill) begin
        dir_if.dir_update_tag_enable = 1'b1;
        dir_if.dir_update_tag_valid  = 1'b1;
        needs_wb_d = tag_l2_valid[tag_miss_fill_l2_way] && tag_l2_dirty[tag_miss_fill_l2_way];
      end

      case (tag_l2req_packet.op)
        L2REQ_STORE, L2REQ_STORE_SYNC: begin
          if (cache_hit || fill) begin
            dir_if.dir_update_dirty[way_in_use] = 1'b1;
            dir_if.dir_new_dirty                = 1'b1;
          end
        end
        L2REQ_LOAD: begin
          // Freshly filled line starts clean.
          if (fill) dir_if.dir_update_dirty[way_in_use] = 1'b1;
          if ((cache_hit || fill) && tag_l2req_packet.unit == L2REQ_UNIT_DCACHE) begin
            dir_if.dir_update_directory = 1'b1;
            dir_if.dir_update_dir_valid = 1'b1;
          end
        end
        L2REQ_FLUSH: begin
          if (cache_hit) begin
            dir_if.dir_update_dirty[hit_way_enc] = 1'b1;
            needs_wb_d = tag_l2_dirty[hit_way_enc];
          end
        end
        L2REQ_DINVALIDATE: begin
          if (cache_hit) begin
            dir_if.dir_update_tag_enable = 1'b1;
            needs_wb_d = tag_l2_dirty[hit_way_enc];
          end
          // Invalidate the core's L1 copy at the way the directory recorded.
          if (!tag_is_l2_fill && tag_l1_has_line[tag_l2req_packet.core]) begin
            dir_if.dir_update_directory = 1'b1;
            dir_if.dir_update_dir_way   = tag_l1_way[tag_l2req_packet.core*2 +: 2];
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pkt_q         <= '0;
      fill_q        <= 1'b0;
      hit_q         <= 1'b0;
      needs_wb_q    <= 1'b0;
      way_q         <= '0;
      old_tag_q     <= '0;
      data_q        <= '0;
      l1_has_line_q <= '0;
      l1_way_q      <= '0;
    end else begin
      pkt_q         <= tag_l2req_packet;
      fill_q        <= fill;
      hit_q         <= cache_hit;
      needs_wb_q    <= needs_wb_d;
      way_q         <= way_in_use;
      old_tag_q     <= get_way_tag(tag_l2_tag, way_in_use);
      data_q        <= tag_data_from_memory;
      l1_has_line_q <= tag_l1_has_line;
      l1_way_q      <= tag_l1_way;
    end
  end

  assign dir_l2req_packet     = pkt_q;
  assign dir_is_l2_fill       = fill_q;
  assign dir_cache_hit        = hit_q;
  assign dir_needs_writeback  = needs_wb_q;
  assign dir_hit_l2_way_q     = way_q;
  assign dir_old_l2_tag       = old_tag_q;
  assign dir_data_from_memory = data_q;
  assign dir_l1_has_line      = l1_has_line_q;
  assign dir_l1_way           = l1_way_q;

  hit_onehot_a: assert property (@(posedge clk) disable iff (reset)
    tag_l2req_packet.valid |-> $onehot0(hit_oh));

endmodule
